cellrv32_gptmr_multi: RTL and testbench

CELLRV32_GPTMR_MULTI -- requirements
Module: cellrv32_gptmr_multi

---
 rtl/cellrv32_gptmr_multi.sv | 147 ++++++++++++++
 tb/tb_cellrv32_gptmr_multi.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_gptmr_multi.sv
// Multi-channel general-purpose timer with bus register window.
// Each channel counts prescaled ticks up to a threshold; matches raise shared, maskable interrupts.
module cellrv32_gptmr_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFF300
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        clkgen_en_o,
  input  logic [7:0]  clkgen_i,
  output logic        irq_o
);

  localparam int unsigned PRSC_W = 3;
  localparam int unsigned SLOT_W = 4;

  logic                rd;
  logic                wr;
  logic                irq_sel;
  logic [SLOT_W-1:0]   slot;
  logic [1:0]          reg_sel;

  logic [NUM_CH-1:0]   en;
  logic [NUM_CH-1:0]   mode;
  logic [NUM_CH-1:0]   tick;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   ien;
  logic [PRSC_W-1:0]   prsc  [NUM_CH];
  logic [CNT_W-1:0]    thres [NUM_CH];
  logic [CNT_W-1:0]    count [NUM_CH];

  logic [NUM_CH-1:0]   ctrl_we;
  logic [NUM_CH-1:0]   thres_we;
  logic [NUM_CH-1:0]   count_we;
  logic [NUM_CH-1:0]   match;
  logic [NUM_CH-1:0]   irq_clr;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign rd          = rden_i & (addr_i[31:8] == BASE_ADDR[31:8]);
  assign wr          = wren_i & (addr_i[31:8] == BASE_ADDR[31:8]);
  assign irq_sel     = (addr_i[7:2] == 6'd0);
  assign slot        = addr_i[7:4];
  assign reg_sel     = addr_i[3:2];
  assign irq_clr     = (wr && irq_sel) ? data_i[NUM_CH-1:0] : '0;
  assign clkgen_en_o = |en;
  assign unused_bits = ^{addr_i[1:0], data_i};

  // Per-channel write strobes and match events; a COUNT write suppresses the match
  always_comb begin
    ctrl_we  = '0;
    thres_we = '0;
    count_we = '0;
    match    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr && (slot == SLOT_W'(n + 1))) begin
        ctrl_we[n]  = (reg_sel == 2'd0);
        thres_we[n] = (reg_sel == 2'd1);
        count_we[n] = (reg_sel == 2'd2);
      end
      match[n] = en[n] & tick[n] & (count[n] == thres[n]) & ~count_we[n];
    end
  end

  // Read data mux; unmapped offsets and absent channels return zero
  always_comb begin
    rdata = '0;
    if (irq_sel) begin
      rdata[NUM_CH-1:0]  = pending;
      rdata[8 +: NUM_CH] = ien;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (slot == SLOT_W'(n + 1)) begin
        case (reg_sel)
          2'd0:    rdata[4:0]       = {mode[n], prsc[n], en[n]};
          2'd1:    rdata[CNT_W-1:0] = thres[n];
          2'd2:    rdata[CNT_W-1:0] = count[n];
          default: rdata            = '0;
        endcase
      end
    end
  end

  // Channel state: software writes take priority over hardware updates
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en   <= '0;
      mode <= '0;
      tick <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        prsc[n]  <= '0;
        thres[n] <= '0;
        count[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        tick[n] <= clkgen_i[prsc[n]];
        if (ctrl_we[n]) begin
          en[n]   <= data_i[0];
          prsc[n] <= data_i[3:1];
          mode[n] <= data_i[4];
        end else if (match[n] && !mode[n]) begin
          en[n] <= 1'b0;
        end
        if (thres_we[n]) begin
          thres[n] <= data_i[CNT_W-1:0];
        end
        if (count_we[n]) begin
          count[n] <= data_i[CNT_W-1:0];
        end else if (match[n]) begin
          if (mode[n]) begin
            count[n] <= '0;
          end
        end else if (en[n] && tick[n]) begin
          count[n] <= count[n] + CNT_W'(1);
        end
      end
    end
  end

  // Interrupt register, combined irq and bus response
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending <= '0;
      ien     <= '0;
      irq_o   <= 1'b0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      if (wr && irq_sel) begin
        ien <= data_i[8 +: NUM_CH];
      end
      pending <= (pending & ~irq_clr) | match;
      irq_o   <= |(pending & ien);
      ack_o   <= rd | wr;
      data_o  <= rd ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_cellrv32_gptmr_multi.sv
// Self-checking bench for cellrv32_gptmr_multi: vector table, directed corner sequences,
// and randomized bus/tick traffic compared every cycle against a behavioural model.
module tb_cellrv32_gptmr_multi;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 8;
  localparam logic [31:0] BASE = 32'hFFFFF300;
  localparam int unsigned MASK = (32'd1 << CW) - 32'd1;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr;
  logic        rden;
  logic        wren;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        clkgen_en;
  logic [7:0]  clkgen;
  logic        irq;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  cellrv32_gptmr_multi #(.NUM_CH(NCH), .CNT_W(CW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rstn_i(rstn), .addr_i(addr), .rden_i(rden), .wren_i(wren),
    .data_i(data_in), .data_o(data_out), .ack_o(ack), .clkgen_en_o(clkgen_en),
    .clkgen_i(clkgen), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_en   [NCH];
  bit          m_mode [NCH];
  bit          m_tick [NCH];
  bit          m_pend [NCH];
  bit          m_ien  [NCH];
  int unsigned m_prsc [NCH];
  int unsigned m_thres[NCH];
  int unsigned m_count[NCH];
  int unsigned m_data;
  bit          m_ack;
  bit          m_irq;

  function automatic int unsigned m_read(input int unsigned off);
    int unsigned v = 0;
    int unsigned ch;
    if (off == 0) begin
      for (int i = 0; i < NCH; i++) v += (32'(m_pend[i]) << i) + (32'(m_ien[i]) << (8 + i));
    end else if (off >= 16) begin
      ch = off / 16 - 1;
      if (ch < NCH) begin
        case (off % 16)
          0: v = 32'(m_en[ch]) + m_prsc[ch] * 2 + 32'(m_mode[ch]) * 16;
          4: v = m_thres[ch];
          8: v = m_count[ch];
          default: v = 0;
        endcase
      end
    end
    return v;
  endfunction

  function automatic bit m_any_en();
    bit a = 0;
    for (int i = 0; i < NCH; i++) a |= m_en[i];
    return a;
  endfunction

  task automatic model_step();
    bit sel, w, r;
    int unsigned off, d, base;
    bit ev[NCH];
    bit ntick[NCH];
    sel = (addr >> 8) == (BASE >> 8);
    w   = sel && wren;
    r   = sel && rden;
    off = addr & 32'hFC;
    d   = data_in;
    m_data = r ? m_read(off) : 0;
    m_ack  = w || r;
    m_irq  = 0;
    for (int i = 0; i < NCH; i++) m_irq |= m_pend[i] && m_ien[i];
    for (int i = 0; i < NCH; i++) begin
      ev[i]    = m_en[i] && m_tick[i] && (m_count[i] == m_thres[i]) && !(w && off == 16 * (i + 1) + 8);
      ntick[i] = clkgen[m_prsc[i]];
    end
    for (int i = 0; i < NCH; i++) begin
      base = 16 * (i + 1);
      if (w && off == base + 8)          m_count[i] = d & MASK;
      else if (ev[i])                    m_count[i] = m_mode[i] ? 0 : m_count[i];
      else if (m_en[i] && m_tick[i])     m_count[i] = (m_count[i] + 1) & MASK;
      if (w && off == base) begin
        m_en[i]   = d[0];
        m_prsc[i] = (d >> 1) & 7;
        m_mode[i] = d[4];
      end else if (ev[i] && !m_mode[i]) begin
        m_en[i] = 0;
      end
      if (w && off == base + 4) m_thres[i] = d & MASK;
      m_tick[i] = ntick[i];
    end
    if (w && off == 0) begin
      for (int i = 0; i < NCH; i++) begin
        if ((d >> i) & 1) m_pend[i] = 0;
        m_ien[i] = (d >> (8 + i)) & 1;
      end
    end
    for (int i = 0; i < NCH; i++) if (ev[i]) m_pend[i] = 1;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        m_en[i] = 0; m_mode[i] = 0; m_tick[i] = 0; m_pend[i] = 0; m_ien[i] = 0;
        m_prsc[i] = 0; m_thres[i] = 0; m_count[i] = 0;
      end
      m_data = 0; m_ack = 0; m_irq = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_data", data_out, m_data);
      chk("model_ack", 32'(ack), 32'(m_ack));
      chk("model_irq", 32'(irq), 32'(m_irq));
      chk("model_clkgen_en", 32'(clkgen_en), 32'(m_any_en()));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; data_in = d; wren = 1'b1;
    @(posedge clk); #1;
    wren = 1'b0; data_in = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic k);
    @(posedge clk); #1;
    addr = a; rden = 1'b1;
    @(posedge clk); #1;
    rden = 1'b0; d = data_out; k = ack;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_data;
    bit          exp_ack;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        k;
    int          prev;
    int          budget;
    int unsigned off;

    rstn = 1'b0; addr = '0; rden = 1'b0; wren = 1'b0; data_in = '0; clkgen = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", data_out, 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_clkgen_en", 32'(clkgen_en), 32'h0);
    rstn = 1'b1;
    chk_on = 1'b1;

    // Register map vectors (no ticks)
    vecs.push_back('{1, BASE + 32'h10, 32'hFFFFFFE0, 32'h0, 1});
    vecs.push_back('{0, BASE + 32'h10, 32'h0,        32'h0, 1});
    vecs.push_back('{1, BASE + 32'h30, 32'h0000001E, 32'h0, 1});
    vecs.push_back('{0, BASE + 32'h30, 32'h0,        32'h1E, 1});
    vecs.push_back('{1, BASE + 32'h30, 32'h0,        32'h0, 1});
    vecs.push_back('{0, BASE + 32'h30, 32'h0,        32'h0, 1});
    vecs.push_back('{1, BASE + 32'h14, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{0, BASE + 32'h14, 32'h0,        32'hFF, 1});
    vecs.push_back('{1, BASE + 32'h48, 32'h12345678, 32'h0, 1});
    vecs.push_back('{0, BASE + 32'h48, 32'h0,        32'h78, 1});
    vecs.push_back('{1, BASE + 32'h48, 32'h0,        32'h0, 1});
    vecs.push_back('{0, BASE + 32'h4C, 32'h0,        32'h0, 1});
    vecs.push_back('{1, BASE + 32'h50, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{0, BASE + 32'h50, 32'h0,        32'h0, 1});
    vecs.push_back('{1, BASE + 32'h00, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{0, BASE + 32'h00, 32'h0,        32'h00000F00, 1});
    vecs.push_back('{1, BASE + 32'h00, 32'h0,        32'h0, 1});
    vecs.push_back('{0, BASE + 32'h04, 32'h0,        32'h0, 1});
    vecs.push_back('{0, 32'hFFFFF400,  32'h0,        32'h0, 0});
    vecs.push_back('{1, 32'hFFFFF210,  32'h1F,       32'h0, 0});
    vecs.push_back('{0, BASE + 32'h10, 32'h0,        32'h0, 1});
    vecs.push_back('{0, BASE + 32'h14, 32'h0,        32'hFF, 1});

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      addr = vecs[i].a; data_in = vecs[i].d;
      wren = vecs[i].is_wr; rden = !vecs[i].is_wr;
      @(posedge clk); #1;
      rden = 1'b0; wren = 1'b0; data_in = '0;
      chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
    end

    // Continuous ch0, THRES=3: count cycles 0..3
    clkgen = 8'hFF;
    bus_write(BASE + 32'h14, 32'd3);
    bus_write(BASE + 32'h10, 32'h11);
    addr = BASE + 32'h18; rden = 1'b1;
    prev = -1;
    for (int s = 0; s < 12; s++) begin
      @(posedge clk); #1;
      if (prev < 0) chk("cont_first_in_range", 32'(data_out <= 3), 32'h1);
      else          chk("cont_seq", data_out, 32'((prev + 1) % 4));
      prev = int'(data_out);
    end
    rden = 1'b0;
    bus_read(BASE, rd, k);
    chk("cont_pending0", rd & 32'h1, 32'h1);
    chk("cont_irq_masked", 32'(irq), 32'h0);
    bus_write(BASE, 32'h100);
    idle(2);
    chk("cont_irq_on", 32'(irq), 32'h1);
    bus_write(BASE + 32'h10, 32'h0);
    bus_write(BASE, 32'h1);
    idle(2);
    chk("cont_irq_off", 32'(irq), 32'h0);

    // Single-shot ch1, THRES=5
    bus_write(BASE + 32'h24, 32'd5);
    bus_write(BASE + 32'h20, 32'h01);
    idle(15);
    bus_read(BASE + 32'h28, rd, k);
    chk("ss_count", rd, 32'd5);
    bus_read(BASE + 32'h20, rd, k);
    chk("ss_ctrl", rd, 32'h0);
    bus_read(BASE, rd, k);
    chk("ss_pending1", rd & 32'h2, 32'h2);
    chk("ss_clkgen_en", 32'(clkgen_en), 32'h0);
    bus_write(BASE, 32'h2);

    // Wrap: COUNT=0xFF, THRES=0x10, continuous
    bus_write(BASE + 32'h14, 32'h10);
    bus_write(BASE + 32'h18, 32'hFF);
    bus_write(BASE + 32'h10, 32'h11);
    addr = BASE + 32'h18; rden = 1'b1;
    for (int s = 0; s < 20; s++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap_s%0d", s), data_out,
          (s == 0) ? 32'hFF : (s <= 17) ? 32'(s - 1) : 32'(s - 18));
    end
    rden = 1'b0;
    bus_write(BASE + 32'h10, 32'h0);
    bus_write(BASE, 32'hF);

    // W1C colliding with ch2 match: set wins
    bus_write(BASE + 32'h34, 32'd2);
    bus_write(BASE + 32'h38, 32'd0);
    bus_write(BASE + 32'h30, 32'h11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr = BASE; data_in = 32'h4; wren = 1'b1;
    @(posedge clk); #1;
    wren = 1'b0; data_in = '0;
    bus_read(BASE, rd, k);
    chk("w1c_collide_pending2", rd & 32'h4, 32'h4);
    bus_write(BASE + 32'h30, 32'h0);
    bus_write(BASE, 32'h4);
    bus_read(BASE, rd, k);
    chk("w1c_clears_pending2", rd & 32'h4, 32'h0);

    // COUNT write colliding with ch2 match: write wins, no pending
    bus_write(BASE + 32'h38, 32'd0);
    bus_write(BASE + 32'h30, 32'h11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr = BASE + 32'h38; data_in = 32'h40; wren = 1'b1;
    @(posedge clk); #1;
    wren = 1'b0; data_in = '0; rden = 1'b1;
    @(posedge clk); #1;
    rden = 1'b0;
    chk("cntwr_collide_count", data_out, 32'h40);
    bus_read(BASE, rd, k);
    chk("cntwr_collide_nopend", rd & 32'h4, 32'h0);
    bus_write(BASE + 32'h30, 32'h0);

    // Randomized traffic, checked each cycle against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      clkgen = 8'($urandom);
      rden = 1'b0; wren = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2: rden = 1'b1;
        3, 4:    wren = 1'b1;
        default: ;
      endcase
      off = $urandom_range(0, 23) * 4;
      addr = ($urandom_range(0, 19) == 0) ? 32'hFFFFF400 + off : BASE + off;
      data_in = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
    end
    @(posedge clk); #1;
    rden = 1'b0; wren = 1'b0; clkgen = 8'hFF;

    // Reset while two channels run with irq asserted
    bus_write(BASE + 32'h14, 32'd2);
    bus_write(BASE + 32'h24, 32'd3);
    bus_write(BASE + 32'h18, 32'd0);
    bus_write(BASE + 32'h28, 32'd0);
    bus_write(BASE, 32'h300);
    bus_write(BASE + 32'h10, 32'h11);
    bus_write(BASE + 32'h20, 32'h11);
    budget = 50;
    while (!irq && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("rst_pre_irq", 32'(irq), 32'h1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("rst_async_irq", 32'(irq), 32'h0);
    chk("rst_async_clkgen_en", 32'(clkgen_en), 32'h0);
    idle(2);
    rstn = 1'b1;
    idle(10);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_clkgen_en", 32'(clkgen_en), 32'h0);
    for (int o = 0; o < 24; o++) begin
      bus_read(BASE + 32'(o * 4), rd, k);
      chk($sformatf("rst_reg_%02h", o * 4), rd, 32'h0);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
